// File: rtl/clock_freq_meter_pkg.sv
// Shared types and helpers for the clock frequency meter and its loopback checks.
package clock_meter_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    GATE = 1'b1
  } meter_state_t;

  // Counters narrower than 32 bits pass their own ceiling as max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/clock_freq_meter_if.sv
// Control and result bundle of clock_freq_meter; master is the meter, slave is software/CSR side.
interface clock_freq_meter_if
  import clock_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             enable;
  logic [31:0]      gate_cycles;
  logic [CNT_W-1:0] edge_count;
  logic             count_valid;
  logic             count_ovf;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             sig_stalled;

  modport master (
    input  enable, gate_cycles,
    output edge_count, count_valid, count_ovf, period, high_time, period_valid, sig_stalled
  );

  modport slave (
    output enable, gate_cycles,
    input  edge_count, count_valid, count_ovf, period, high_time, period_valid, sig_stalled
  );
endinterface

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus registered-compare rise/fall strobes.
module sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_async,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic sync_p0, sync_p1, sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_d  <= 1'b0;
    end else begin
      sync_p0 <= sig_async;
      sync_p1 <= sync_p0;
      sync_d  <= sync_p1;
    end
  end

  assign sync = sync_p1;
  assign rise = sync_p1 & ~sync_d;
  assign fall = ~sync_p1 & sync_d;
endmodule

// File: rtl/clock_freq_meter.sv
// Gated edge counter for looped-back divided clocks; period/high-time measurement is
// included when CLOCK_FREQ_METER_PERIOD_EN is defined. CNT_W must not exceed 32.
module clock_freq_meter
  import clock_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sig_in,
  clock_freq_meter_if.master mif
);
  localparam logic [31:0]      CNT_MAX   = 32'((64'd1 << CNT_W) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX_W = CNT_MAX[CNT_W-1:0];

  meter_state_t     state, state_nxt;
  logic             start, win_end;
  logic             sync, rise, fall;
  logic [31:0]      gate_len, gate_cnt, load_len;
  logic [CNT_W-1:0] edge_cnt, edge_inc;
  logic             ovf, ovf_hit;
  logic [CNT_W-1:0] edge_count_r;
  logic             count_valid_r, count_ovf_r, sig_stalled_r;

  sig_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sig_async (sig_in),
    .sync      (sync),
    .rise      (rise),
    .fall      (fall)
  );

  assign load_len = (mif.gate_cycles == 32'd0) ? 32'd1 : mif.gate_cycles;
  assign edge_inc = rise ? CNT_W'(sat_inc(32'(edge_cnt), CNT_MAX)) : edge_cnt;
  assign ovf_hit  = rise && (edge_cnt == CNT_MAX_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    win_end   = 1'b0;
    case (state)
      IDLE: begin
        if (mif.enable) begin
          state_nxt = GATE;
          start     = 1'b1;
        end
      end
      GATE: begin
        if (!mif.enable)                      state_nxt = IDLE;
        else if (gate_cnt == gate_len - 32'd1) win_end  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window counters and edge-count results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_len      <= 32'd1;
      gate_cnt      <= '0;
      edge_cnt      <= '0;
      ovf           <= 1'b0;
      edge_count_r  <= '0;
      count_valid_r <= 1'b0;
      count_ovf_r   <= 1'b0;
      sig_stalled_r <= 1'b0;
    end else begin
      count_valid_r <= 1'b0;
      if (start) begin
        gate_len <= load_len;
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf      <= 1'b0;
      end else if (state == GATE && mif.enable) begin
        if (win_end) begin
          edge_count_r  <= edge_inc;
          count_ovf_r   <= ovf | ovf_hit;
          sig_stalled_r <= (edge_inc == '0);
          count_valid_r <= 1'b1;
          gate_len      <= load_len;
          gate_cnt      <= '0;
          edge_cnt      <= '0;
          ovf           <= 1'b0;
        end else begin
          gate_cnt <= gate_cnt + 32'd1;
          edge_cnt <= edge_inc;
          ovf      <= ovf | ovf_hit;
        end
      end else begin
        // Leaving GATE or idling: the partial window is dropped.
        gate_cnt <= '0;
        edge_cnt <= '0;
        ovf      <= 1'b0;
      end
    end
  end

  assign mif.edge_count  = edge_count_r;
  assign mif.count_valid = count_valid_r;
  assign mif.count_ovf   = count_ovf_r;
  assign mif.sig_stalled = sig_stalled_r;

`ifdef CLOCK_FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_cnt, hi_cnt, period_r, high_time_r;
  logic             period_valid_r, seen_rise;

  // Period and high-time measurement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt        <= '0;
      hi_cnt         <= '0;
      seen_rise      <= 1'b0;
      period_r       <= '0;
      high_time_r    <= '0;
      period_valid_r <= 1'b0;
    end else begin
      period_valid_r <= 1'b0;
      if (state != GATE) begin
        per_cnt   <= '0;
        hi_cnt    <= '0;
        seen_rise <= 1'b0;
      end else begin
        if (rise) begin
          per_cnt   <= CNT_W'(1);
          seen_rise <= 1'b1;
          if (seen_rise) begin
            period_r       <= per_cnt;
            period_valid_r <= 1'b1;
          end
        end else begin
          per_cnt <= CNT_W'(sat_inc(32'(per_cnt), CNT_MAX));
        end
        if (fall) begin
          high_time_r <= hi_cnt;
          hi_cnt      <= '0;
        end else if (sync) begin
          hi_cnt <= CNT_W'(sat_inc(32'(hi_cnt), CNT_MAX));
        end
      end
    end
  end

  assign mif.period       = period_r;
  assign mif.high_time    = high_time_r;
  assign mif.period_valid = period_valid_r;
`else
  logic unused_period_inputs;
  assign unused_period_inputs = sync ^ fall;
  assign mif.period       = '0;
  assign mif.high_time    = '0;
  assign mif.period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_clock_freq_meter.sv
// Directed bench for clock_freq_meter: table of steady-state windows plus corner-case sequences.
`timescale 1ns/1ps
module tb_clock_freq_meter;
  import clock_meter_pkg::*;

`ifdef CLOCK_FREQ_METER_PERIOD_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sig_in = 1'b0;
  logic sig2 = 1'b0;

  always #5 clk = ~clk;

  clock_freq_meter_if #(.CNT_W(32)) mif ();
  clock_freq_meter_if #(.CNT_W(4))  mif2 ();

  clock_freq_meter #(.CNT_W(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .mif    (mif)
  );

  clock_freq_meter #(.CNT_W(4)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig2),
    .mif    (mif2)
  );

  typedef struct {
    int gate;
    int hi;
    int lo;
    int exp_cnt;
    bit exp_stall;
    int exp_per;
    int exp_high;
  } vec_t;

  vec_t vecs[6];
  int checks = 0;
  int errors = 0;
  int gen_hi = 0;
  int gen_lo = 0;
  int gen_ph = 0;
  bit pv_seen = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clk cycle; sig_in follows the hi/lo generator when gen_hi is non-zero.
  task automatic tick();
    @(negedge clk);
    if (mif.period_valid) pv_seen = 1'b1;
    if (gen_hi != 0) begin
      gen_ph++;
      if (sig_in && gen_ph >= gen_hi) begin
        sig_in = 1'b0;
        gen_ph = 0;
      end else if (!sig_in && gen_ph >= gen_lo) begin
        sig_in = 1'b1;
        gen_ph = 0;
      end
    end
  endtask

  task automatic wait_valid(input bit sel, input int limit, output int n);
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < limit) begin
      tick();
      n++;
      got = sel ? mif2.count_valid : mif.count_valid;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_valid dut%0d: no count_valid within %0d cycles", sel + 1, limit);
    end
  endtask

  initial begin
    int n, ones, cv, prev;
    vecs[0] = '{80, 4, 4, 10, 1'b0, 8, 4};
    vecs[1] = '{50, 0, 0, 0, 1'b1, 0, 0};
    vecs[2] = '{100, 5, 5, 10, 1'b0, 10, 5};
    vecs[3] = '{60, 2, 4, 10, 1'b0, 6, 2};
    vecs[4] = '{64, 3, 1, 16, 1'b0, 4, 3};
    vecs[5] = '{7, 0, 0, 0, 1'b1, 0, 0};

    mif.enable = 1'b0;  mif.gate_cycles = 32'd0;
    mif2.enable = 1'b0; mif2.gate_cycles = 32'd60;
    tick(); tick();
    check("rst edge_count", mif.edge_count, 0);
    check("rst count_valid", mif.count_valid, 0);
    check("rst count_ovf", mif.count_ovf, 0);
    check("rst sig_stalled", mif.sig_stalled, 0);
    check("rst period", mif.period, 0);
    check("rst high_time", mif.high_time, 0);
    check("rst period_valid", mif.period_valid, 0);
    check("rst dut2 edge_count", mif2.edge_count, 0);

    // Steady-state windows from the vector table
    for (int v = 0; v < 6; v++) begin
      mif.enable = 1'b0;
      rst_n = 1'b0;
      gen_hi = vecs[v].hi; gen_lo = vecs[v].lo; gen_ph = 0; sig_in = 1'b0;
      tick(); tick();
      check("vec reset edge_count", mif.edge_count, 0);
      rst_n = 1'b1;
      mif.gate_cycles = vecs[v].gate;
      mif.enable = 1'b1;
      pv_seen = 1'b0;
      wait_valid(1'b0, vecs[v].gate + 10, n);
      wait_valid(1'b0, vecs[v].gate + 10, n);
      check("vec window interval", n, vecs[v].gate);
      wait_valid(1'b0, vecs[v].gate + 10, n);
      check("vec edge_count", mif.edge_count, vecs[v].exp_cnt);
      check("vec count_ovf", mif.count_ovf, 0);
      check("vec sig_stalled", mif.sig_stalled, vecs[v].exp_stall);
      check("vec period", mif.period, PER_EN ? vecs[v].exp_per : 0);
      check("vec high_time", mif.high_time, PER_EN ? vecs[v].exp_high : 0);
      check("vec period_valid seen", pv_seen, PER_EN && !vecs[v].exp_stall);
    end

    // gate_cycles = 0 acts as 1-cycle windows; signal toggling every cycle
    mif.enable = 1'b0; rst_n = 1'b0;
    gen_hi = 1; gen_lo = 1; gen_ph = 0; sig_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1; mif.gate_cycles = 32'd0; mif.enable = 1'b1;
    wait_valid(1'b0, 10, n);
    for (int k = 0; k < 4; k++) wait_valid(1'b0, 5, n);
    ones = 0;
    prev = 0;
    for (int k = 0; k < 6; k++) begin
      wait_valid(1'b0, 5, n);
      check("gate0 interval", n, 1);
      ones += int'(mif.edge_count);
      if (k % 2 == 1) check("gate0 pair sum", int'(mif.edge_count) + prev, 1);
      prev = int'(mif.edge_count);
    end
    check("gate0 total edges", ones, 3);
    check("gate0 period", mif.period, PER_EN ? 2 : 0);
    check("gate0 high_time", mif.high_time, PER_EN ? 1 : 0);

    // Rise on the final window cycle, then gate_cycles changed mid-window
    mif.enable = 1'b0; rst_n = 1'b0;
    gen_hi = 0; sig_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1; mif.gate_cycles = 32'd20; mif.enable = 1'b1;
    wait_valid(1'b0, 30, n);
    repeat (17) tick();
    sig_in = 1'b1;
    mif.gate_cycles = 32'd30;
    wait_valid(1'b0, 10, n);
    check("edge-at-end latency", n, 3);
    check("edge-at-end edge_count", mif.edge_count, 1);
    check("edge-at-end sig_stalled", mif.sig_stalled, 0);
    wait_valid(1'b0, 40, n);
    check("new gate_len applied", n, 30);
    check("after-end edge_count", mif.edge_count, 0);
    check("after-end sig_stalled", mif.sig_stalled, 1);

    // enable dropped mid-window, then rst_n pulsed mid-window
    mif.enable = 1'b0; rst_n = 1'b0;
    gen_hi = 4; gen_lo = 4; gen_ph = 0; sig_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1; mif.gate_cycles = 32'd80; mif.enable = 1'b1;
    wait_valid(1'b0, 100, n);
    wait_valid(1'b0, 100, n);
    repeat (30) tick();
    mif.enable = 1'b0;
    cv = 0;
    repeat (100) begin
      tick();
      if (mif.count_valid) cv++;
    end
    check("disable no count_valid", cv, 0);
    check("disable edge_count held", mif.edge_count, 10);
    check("disable sig_stalled held", mif.sig_stalled, 0);
    mif.enable = 1'b1;
    wait_valid(1'b0, 200, n);
    check("re-enable window length", n, 81);
    check("re-enable edge_count", mif.edge_count, 10);
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    check("mid rst edge_count", mif.edge_count, 0);
    check("mid rst sig_stalled", mif.sig_stalled, 0);
    check("mid rst period", mif.period, 0);
    cv = 0;
    repeat (3) begin
      tick();
      if (mif.count_valid) cv++;
    end
    check("mid rst no count_valid", cv, 0);
    rst_n = 1'b1;
    wait_valid(1'b0, 200, n);
    check("post-rst window length", n, 81);

    // Saturation on the 4-bit instance, then recovery in the next window
    gen_hi = 0;
    sig2 = 1'b0;
    mif2.gate_cycles = 32'd60;
    mif2.enable = 1'b1;
    wait_valid(1'b1, 70, n);
    check("cnt4 quiet edge_count", mif2.edge_count, 0);
    check("cnt4 quiet sig_stalled", mif2.sig_stalled, 1);
    for (int k = 0; k < 50; k++) begin
      sig2 = ~sig2;
      tick();
    end
    wait_valid(1'b1, 20, n);
    check("cnt4 sat edge_count", mif2.edge_count, 15);
    check("cnt4 sat count_ovf", mif2.count_ovf, 1);
    check("cnt4 sat sig_stalled", mif2.sig_stalled, 0);
    for (int k = 0; k < 6; k++) begin
      sig2 = ~sig2;
      tick();
    end
    wait_valid(1'b1, 70, n);
    check("cnt4 recover edge_count", mif2.edge_count, 3);
    check("cnt4 recover count_ovf", mif2.count_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_freq_meter.md
# clock_freq_meter

Measures a derived clock or PWM signal against the main clock `clk`: counts rising edges over a programmable gate window and, optionally, the period and high time of the signal. It is the receiving end of the clock-generation path. Divided clocks (FSM, image, motor PWM) are looped back to it so software can check the real frequency and duty cycle against the programmed divider thresholds.

## Interface
- CNT_W, 32: width of all count, period and high-time results.
- clk  in  1: main system clock; all logic runs on its rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- enable  in  1: high runs back-to-back gate windows; low returns the block to IDLE.
- gate_cycles  in  32: window length in `clk` cycles; sampled at each window start; 0 is treated as 1.
- sig_in  in  1: measured signal, asynchronous to `clk`.
- edge_count  out  CNT_W: rising edges counted in the last completed window.
- count_valid  out  1: one-cycle pulse when `edge_count` updates.
- count_ovf  out  1: the last window's edge counter saturated.
- period  out  CNT_W: `clk` cycles between the last two rising edges.
- high_time  out  CNT_W: `clk` cycles `sig_in` was high in the last completed high phase.
- period_valid  out  1: one-cycle pulse when `period` and `high_time` update.
- sig_stalled  out  1: no rising edge seen during the last completed window.

## Operation
- Input path:
  - 2-FF synchronizer, then a delayed copy for edge detection.
  - `rise` = sync & ~sync_d; `fall` = ~sync & sync_d.
- FSM states: IDLE, GATE.
  - IDLE: counters cleared. `enable`=1 moves to GATE, loads `gate_len` = max(gate_cycles, 1) and sets `gate_cnt` = 0.
  - GATE: `gate_cnt` increments each cycle; `edge_cnt` increments on `rise`, saturating at 2^CNT_W-1 and setting the internal ovf flag.
  - GATE window end (`gate_cnt` == `gate_len`-1), all on the next edge:
    - `edge_count` takes `edge_cnt` plus the rise on that final cycle.
    - `count_ovf` and `sig_stalled` update.
    - `count_valid` pulses.
    - Counters clear, `gate_len` reloads, state stays GATE.
  - `enable`=0 in any state: IDLE next cycle. The partial window is discarded with no `count_valid`, and result outputs hold their values.
- Period measurement:
  - Free-running cycle counter `per_cnt`, saturating; it restarts at 1 on each `rise`.
  - On `rise`: `period` takes `per_cnt` and `period_valid` pulses, but only if a previous rise has been seen since reset or since entering GATE.
  - `hi_cnt` counts cycles while the synchronized signal is high; `high_time` latches it on `fall`.
  - Active only in GATE.
- Reset value of every output is 0.

## Timing
- `sig_in` to `rise`: 3 `clk` cycles (2 sync flops + edge register). An edge is counted in the window where `rise` is asserted.
- `count_valid` is asserted the cycle after the final window cycle.
- Window length is exactly `gate_len` cycles, and windows are contiguous with no dead cycle.
- Frequency = `edge_count` × f_clk / `gate_len`.
- Maximum measurable input frequency is f_clk/2; higher frequencies alias.
- `rise` and window end in the same cycle: the edge counts in the closing window.
- `gate_cycles` changes mid-window: no effect until the next window.
- `rst_n` low mid-window: all state and outputs clear immediately, and no valid pulse is issued.

## Configuration
- `CLOCK_FREQ_METER_PERIOD_EN`:
  - Defined: period and high-time logic present.
  - Undefined: that logic is removed, and `period`, `high_time` and `period_valid` are tied to 0.
  - Edge counting is identical either way.

## Structure
- Package `clock_meter_pkg`:
  - FSM state enum (IDLE, GATE).
  - Default CNT_W constant.
  - Saturating-increment helper function.
- Sub-module `sig_sync_edge`: 2-FF synchronizer plus rise/fall detector with `clk`/`rst_n`. It is reused for other asynchronous inputs.

## Test plan
- `sig_in` period 8 `clk` (4 high/4 low), `gate_cycles`=80, `enable`=1 → each `count_valid` shows `edge_count`=10, `period`=8, `high_time`=4, `sig_stalled`=0.
- `sig_in` held 0, `gate_cycles`=50 → `count_valid` every 50 cycles, `edge_count`=0, `sig_stalled`=1, no `period_valid`.
- `gate_cycles`=0, `sig_in` toggling every cycle → window of 1 cycle, `count_valid` every cycle, `edge_count` alternates 0/1.
- CNT_W=4 with 20 edges in a window → `edge_count`=15, `count_ovf`=1; the next window with 3 edges gives `edge_count`=3, `count_ovf`=0.
- `enable` dropped mid-window, or `rst_n` pulsed mid-window → no `count_valid`. With `enable`: outputs hold. With `rst_n`: outputs are 0. Re-enable gives a full-length window.
- Rise landing on the final window cycle → counted in that window's `edge_count` and not in the next.
